// File: rtl/core_pkg.sv
// Shared core definitions: memory-op encodings, access-sequencer states and
// the captured request record used by the memory stage.
package core_pkg;

    localparam int DMEM_W = 16;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_RD   = 2'b01,
        MEM_WR   = 2'b10,
        MEM_RSVD = 2'b11
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_DONE
    } acc_state_t;

    typedef struct packed {
        mem_op_t               op;
        logic                  wide;
        logic [2*DMEM_W-1:0]   wrdata;
    } mem_req_t;

    // Only read and write start an access; reserved behaves like none.
    function automatic logic is_access(input mem_op_t op);
        return (op == MEM_RD) || (op == MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Per-beat wait-state counter; expired fires on the last allowed wait cycle
// so the sequencer leaves the beat exactly MaxWait cycles after entering it.
module mem_wait_timer #(
    parameter int MaxWait = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int CW = (MaxWait < 2) ? 1 : $clog2(MaxWait + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (count)
            cnt <= cnt + CW'(1);
    end

    assign expired = count && (cnt == CW'(MaxWait - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: splits 32-bit transfers into two 16-bit beats,
// assembles read data for MEM/WB and stalls upstream while an access is live.
module mem_access_ctrl
    import core_pkg::*;
#(
    parameter int AddrWidth = 20,
    parameter int MaxWait   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           i_MemOp,
    input  logic                 i_Wide,
    input  logic [AddrWidth-1:0] i_Addr,
    input  logic [31:0]          i_WrData,
    input  logic                 i_MemReady,
    input  logic [DMEM_W-1:0]    i_RdData,
    output logic                 o_MemRd,
    output logic                 o_MemWr,
    output logic [AddrWidth-1:0] o_MemAddr,
    output logic [DMEM_W-1:0]    o_MemWrData,
    output logic [31:0]          o_MemData,
    output logic                 o_WbEnable,
    output logic                 o_Stall,
    output logic                 o_Fault
);

    acc_state_t           state, next_state;
    mem_req_t             req_q;
    logic [AddrWidth-1:0] addr_q;
    logic                 fault_q;
    logic                 in_beat;
    logic                 beat_ok;
    logic                 expired;
    mem_op_t              op_in;

    assign op_in   = mem_op_t'(i_MemOp);
    assign in_beat = (state == ST_BEAT0) || (state == ST_BEAT1);
    assign beat_ok = in_beat && i_MemReady;

    // Counter is held clear outside beats and on each completed beat, so it
    // starts from zero on entry to every beat.
    mem_wait_timer #(.MaxWait(MaxWait)) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_beat || i_MemReady),
        .count   (in_beat && !i_MemReady),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (is_access(op_in)) next_state = ST_BEAT0;
            ST_BEAT0: begin
                if (i_MemReady)
                    next_state = req_q.wide ? ST_BEAT1 : ST_DONE;
                else if (expired)
                    next_state = ST_DONE;
            end
            ST_BEAT1: if (i_MemReady || expired) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Every output is gated by rst so reset forces them low without waiting
    // for a clock.
    always_comb begin
        o_MemRd     = 1'b0;
        o_MemWr     = 1'b0;
        o_MemAddr   = '0;
        o_MemWrData = '0;
        o_WbEnable  = 1'b0;
        o_Stall     = 1'b0;
        o_Fault     = 1'b0;
        if (rst) begin
            case (state)
                ST_IDLE: begin
                    o_Stall    = is_access(op_in);
                    o_WbEnable = !is_access(op_in);
                end
                ST_BEAT0: begin
                    o_Stall     = 1'b1;
                    o_MemRd     = (req_q.op == MEM_RD);
                    o_MemWr     = (req_q.op == MEM_WR);
                    o_MemAddr   = addr_q;
                    o_MemWrData = req_q.wide ? req_q.wrdata[31:16] : req_q.wrdata[15:0];
                end
                ST_BEAT1: begin
                    o_Stall     = 1'b1;
                    o_MemRd     = (req_q.op == MEM_RD);
                    o_MemWr     = (req_q.op == MEM_WR);
                    o_MemAddr   = addr_q + AddrWidth'(1);
                    o_MemWrData = req_q.wrdata[15:0];
                end
                ST_DONE: begin
                    o_WbEnable = 1'b1;
                    o_Fault    = fault_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q     <= '0;
            addr_q    <= '0;
            o_MemData <= '0;
            fault_q   <= 1'b0;
        end else begin
            if (state == ST_IDLE && is_access(op_in)) begin
                req_q.op     <= op_in;
                req_q.wide   <= i_Wide;
                req_q.wrdata <= i_WrData;
                addr_q       <= i_Addr;
            end

            // Read data only moves on completed read beats; writes and
            // aborted accesses leave the last value in place.
            if (beat_ok && req_q.op == MEM_RD) begin
                if (state == ST_BEAT0) begin
                    if (req_q.wide)
                        o_MemData[31:16] <= i_RdData;
                    else
                        o_MemData <= {16'h0000, i_RdData};
                end else begin
                    o_MemData[15:0] <= i_RdData;
                end
            end

            if (in_beat && !i_MemReady && expired)
                fault_q <= 1'b1;
            else if (state == ST_DONE)
                fault_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: stimulus pushes expected beats and
// results into queues, a negedge monitor pops and compares them.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  i_MemOp = 2'b00;
    logic        i_Wide = 1'b0;
    logic [19:0] i_Addr = '0;
    logic [31:0] i_WrData = '0;
    logic        i_MemReady = 1'b0;
    logic [15:0] i_RdData = '0;
    logic        o_MemRd, o_MemWr;
    logic [19:0] o_MemAddr;
    logic [15:0] o_MemWrData;
    logic [31:0] o_MemData;
    logic        o_WbEnable, o_Stall, o_Fault;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    typedef struct { logic is_wr; logic [19:0] addr; logic [15:0] data; } beat_t;
    typedef struct { logic [31:0] md; logic fault; int stall; } res_t;
    typedef struct {
        logic [1:0] op; logic wide; logic [19:0] addr; logic [31:0] wd;
        int w0; int w1; logic [15:0] r0; logic [15:0] r1;
        logic [19:0] ea0; logic [15:0] ed0; logic [19:0] ea1; logic [15:0] ed1;
        logic [31:0] md; logic fault; int stall;
    } vec_t;

    beat_t beat_q[$];
    res_t  res_q[$];
    vec_t  vecs[6];

    mem_access_ctrl #(.AddrWidth(20), .MaxWait(15)) dut (
        .clk(clk), .rst(rst), .i_MemOp(i_MemOp), .i_Wide(i_Wide), .i_Addr(i_Addr),
        .i_WrData(i_WrData), .i_MemReady(i_MemReady), .i_RdData(i_RdData),
        .o_MemRd(o_MemRd), .o_MemWr(o_MemWr), .o_MemAddr(o_MemAddr),
        .o_MemWrData(o_MemWrData), .o_MemData(o_MemData), .o_WbEnable(o_WbEnable),
        .o_Stall(o_Stall), .o_Fault(o_Fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            stall_cnt = 0;
        end else begin
            if (o_Stall) stall_cnt++;
            if ((o_MemRd || o_MemWr) && i_MemReady) begin
                if (beat_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected addr=%h rd=%b wr=%b", o_MemAddr, o_MemRd, o_MemWr);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("beat_is_wr", {31'd0, o_MemWr}, {31'd0, b.is_wr});
                    chk("beat_strobe_excl", {31'd0, o_MemRd & o_MemWr}, 32'd0);
                    chk("beat_addr", {12'd0, o_MemAddr}, {12'd0, b.addr});
                    if (b.is_wr) chk("beat_wrdata", {16'd0, o_MemWrData}, {16'd0, b.data});
                end
            end
            if (o_WbEnable && stall_cnt > 0) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL result_unexpected md=%h", o_MemData);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("res_memdata", o_MemData, r.md);
                    chk("res_fault", {31'd0, o_Fault}, {31'd0, r.fault});
                    chk("res_stall_cycles", stall_cnt, r.stall);
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        i_MemOp = v.op; i_Wide = v.wide; i_Addr = v.addr; i_WrData = v.wd;
        i_MemReady = 1'b0;
        if (v.w0 < 15) beat_q.push_back('{v.op == 2'b10, v.ea0, v.ed0});
        if (v.wide && v.w0 < 15 && v.w1 < 15) beat_q.push_back('{v.op == 2'b10, v.ea1, v.ed1});
        res_q.push_back('{v.md, v.fault, v.stall});
        @(posedge clk); #1;
        i_MemOp = 2'b00;
        for (int b = 0; b < (v.wide ? 2 : 1); b++) begin
            int w;
            w = (b == 0) ? v.w0 : v.w1;
            if (w >= 15) begin
                i_MemReady = 1'b0;
                repeat (15) begin @(posedge clk); #1; end
                break;
            end
            repeat (w) begin i_MemReady = 1'b0; @(posedge clk); #1; end
            i_MemReady = 1'b1;
            i_RdData = (b == 0) ? v.r0 : v.r1;
            @(posedge clk); #1;
            i_MemReady = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b10, 1'b1, 20'h0FFFE, 32'hDEADBEEF, 0, 0, 16'h0, 16'h0,
                    20'h0FFFE, 16'hDEAD, 20'h0FFFF, 16'hBEEF, 32'h0, 1'b0, 3};
        vecs[1] = '{2'b01, 1'b1, 20'hFFFFF, 32'h0, 0, 0, 16'h1234, 16'h5678,
                    20'hFFFFF, 16'h0, 20'h00000, 16'h0, 32'h12345678, 1'b0, 3};
        vecs[2] = '{2'b01, 1'b0, 20'h00100, 32'h0, 2, 0, 16'hABCD, 16'h0,
                    20'h00100, 16'h0, 20'h0, 16'h0, 32'h0000ABCD, 1'b0, 4};
        vecs[3] = '{2'b10, 1'b0, 20'h00010, 32'hFFFF5A5A, 1, 0, 16'h0, 16'h0,
                    20'h00010, 16'h5A5A, 20'h0, 16'h0, 32'h0000ABCD, 1'b0, 3};
        vecs[4] = '{2'b01, 1'b0, 20'h00200, 32'h0, 15, 0, 16'h0, 16'h0,
                    20'h0, 16'h0, 20'h0, 16'h0, 32'h0000ABCD, 1'b1, 16};
        vecs[5] = '{2'b01, 1'b1, 20'h12345, 32'h0, 1, 2, 16'hCAFE, 16'hF00D,
                    20'h12345, 16'h0, 20'h12346, 16'h0, 32'hCAFEF00D, 1'b0, 6};

        // Reset held with a read requested: everything forced low.
        rst = 1'b0; i_MemOp = 2'b01;
        #3;
        chk("rst_memrd", {31'd0, o_MemRd}, 32'd0);
        chk("rst_memwr", {31'd0, o_MemWr}, 32'd0);
        chk("rst_stall", {31'd0, o_Stall}, 32'd0);
        chk("rst_wbenable", {31'd0, o_WbEnable}, 32'd0);
        chk("rst_memdata", o_MemData, 32'd0);
        #20; i_MemOp = 2'b00; rst = 1'b1;
        @(negedge clk);
        chk("idle_wbenable", {31'd0, o_WbEnable}, 32'd1);
        chk("idle_stall", {31'd0, o_Stall}, 32'd0);
        chk("idle_fault", {31'd0, o_Fault}, 32'd0);
        @(posedge clk); #1;

        // Reserved op behaves as none.
        i_MemOp = 2'b11;
        @(negedge clk);
        chk("rsvd_stall", {31'd0, o_Stall}, 32'd0);
        chk("rsvd_wbenable", {31'd0, o_WbEnable}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsvd_still_idle", {31'd0, o_Stall | o_MemRd | o_MemWr}, 32'd0);
        @(posedge clk); #1;
        i_MemOp = 2'b00;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset asserted during BEAT1 of a wide read.
        i_MemOp = 2'b01; i_Wide = 1'b1; i_Addr = 20'hAAAAA;
        beat_q.push_back('{1'b0, 20'hAAAAA, 16'h0});
        @(posedge clk); #1;
        i_MemOp = 2'b00; i_MemReady = 1'b1; i_RdData = 16'h1111;
        @(posedge clk); #1;
        i_MemReady = 1'b0;
        #1;
        chk("beat1_memrd_pre_rst", {31'd0, o_MemRd}, 32'd1);
        rst = 1'b0;
        #1;
        chk("midrst_memrd", {31'd0, o_MemRd}, 32'd0);
        chk("midrst_memwr", {31'd0, o_MemWr}, 32'd0);
        chk("midrst_stall", {31'd0, o_Stall}, 32'd0);
        chk("midrst_addr", {12'd0, o_MemAddr}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_wbenable", {31'd0, o_WbEnable}, 32'd1);
        chk("post_rst_stall", {31'd0, o_Stall}, 32'd0);
        chk("post_rst_memdata", o_MemData, 32'd0);
        @(posedge clk); #1;

        chk("beat_q_empty", beat_q.size(), 32'd0);
        chk("res_q_empty", res_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
